// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//   AHB-Lite encodings and defaults shared by the bus master and the slaves
//   on the system interconnect.
//
//   htrans_t      : HTRANS transfer types
//   hsize_t       : HSIZE encodings used on this 32-bit bus
//   HBURST_SINGLE : only burst type this system issues
//   HPROT_DEFAULT : non-cacheable, non-bufferable, privileged data access
//   align_addr()  : clears the address bits that a transfer size makes
//                   meaningless, so HADDR is always size-aligned
// ---------------------------------------------------------------------------
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      BYTE = 3'b000,
      HALF = 3'b001,
      WORD = 3'b010
   } hsize_t;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   // Byte transfers keep every address bit; halfwords drop bit 0; words drop
   // bits 1:0. Illegal sizes are passed through untouched.
   function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                              input logic [2:0]  size);
      logic [31:0] a;
      a = addr;
      case (size)
         HALF:    a[0]   = 1'b0;
         WORD:    a[1:0] = 2'b00;
         default: a      = addr;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
//   Generic AHB-Lite initiator. Takes single read/write commands on a
//   valid/ready port and issues SINGLE NONSEQ transfers, overlapping the
//   address phase of the next command with the data phase of the current
//   one. One response per command, returned in order.
//
//   Parameters
//     HPROT_VALUE : constant driven on HPROT
//
//   Ports
//     HCLK, HRESETn          : clock, synchronous active-low reset
//     cmd_valid / cmd_ready  : command handshake
//     cmd_write, cmd_addr,
//     cmd_size, cmd_wdata    : command payload (wdata already lane-aligned)
//     rsp_valid              : one-cycle pulse per completed command
//     rsp_rdata, rsp_err     : read data (0 for writes) and HRESP at completion
//     busy                   : a transfer is in address or data phase
//     HADDR..HWDATA          : AHB-Lite master outputs, all from flops
//     HRDATA, HREADY, HRESP  : AHB-Lite slave-side inputs
//
//   Pipeline
//     A stage holds the transfer currently in its address phase, D stage the
//     transfer in its data phase. Both advance together on HREADY=1.
// ---------------------------------------------------------------------------
module ahb_lite_master
   import ahb_pkg::*;
#(
   parameter logic [3:0] HPROT_VALUE = HPROT_DEFAULT
) (
   input  logic        HCLK,
   input  logic        HRESETn,

   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic [31:0] cmd_wdata,

   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,

   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HWRITE,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   // Address stage
   logic        a_valid;
   logic [31:0] a_addr;
   logic [2:0]  a_size;
   logic        a_write;
   logic [31:0] a_wdata;

   // Data stage
   logic        d_valid;
   logic        d_write;
   logic [31:0] d_wdata;

   logic        cmd_accept;
   logic        d_complete;

   // A pending address phase may only be replaced when the bus accepts it
   // (HREADY=1). An empty A stage can always load, even during a wait state:
   // going IDLE -> NONSEQ while HREADY is low is legal AHB-Lite.
   assign cmd_ready  = HREADY || !a_valid;
   assign cmd_accept = cmd_valid && cmd_ready;
   assign d_complete = HREADY && d_valid;

   // -------------------------------------------------------------------------
   // Address stage. cmd_ready already encodes "A is free to change", so the
   // same rule covers the HREADY=1 advance and the load-during-wait case.
   // When A empties, the payload registers keep their last value; HTRANS=IDLE
   // makes them don't-care on the bus.
   // -------------------------------------------------------------------------
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         a_valid <= 1'b0;
         a_addr  <= '0;
         a_size  <= '0;
         a_write <= 1'b0;
         a_wdata <= '0;
      end else if (cmd_ready) begin
         a_valid <= cmd_accept;
         if (cmd_accept) begin
            a_addr  <= align_addr(cmd_addr, cmd_size);
            a_size  <= cmd_size;
            a_write <= cmd_write;
            a_wdata <= cmd_wdata;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Data stage plus response. D only moves on HREADY=1; the payload is only
   // reloaded when a real transfer enters, which keeps HWDATA steady after the
   // last write instead of shadowing a stale A payload.
   // -------------------------------------------------------------------------
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         d_valid   <= 1'b0;
         d_write   <= 1'b0;
         d_wdata   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (HREADY) begin
            d_valid <= a_valid;
            if (a_valid) begin
               d_write <= a_write;
               d_wdata <= a_wdata;
            end
         end

         // Response fields are zero outside the pulse so consumers that peek
         // at them off-pulse see something deterministic.
         rsp_valid <= d_complete;
         if (d_complete) begin
            rsp_rdata <= d_write ? 32'h0 : HRDATA;
            rsp_err   <= HRESP;
         end else begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end
      end
   end

   // Bus outputs: everything comes straight from stage registers.
   assign HTRANS    = a_valid ? NONSEQ : IDLE;
   assign HADDR     = a_addr;
   assign HSIZE     = a_size;
   assign HWRITE    = a_write;
   assign HWDATA    = d_wdata;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_VALUE;
   assign HMASTLOCK = 1'b0;

   assign busy = a_valid || d_valid;

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;
   import ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;

   always #5 HCLK = ~HCLK;

   ahb_lite_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      logic [31:0] addr;
      logic [2:0]  size;
      logic        write;
      logic [31:0] wdata;
      bit          in_data;
   } txn_t;

   txn_t        q[$];          // outstanding commands, oldest first
   bit          exp_rv = 0;
   logic [31:0] exp_rd = '0;
   logic        exp_err = 1'b0;
   bit          seen_rst = 0;

   function automatic logic [31:0] ref_align(input logic [31:0] a, input logic [2:0] s);
      if (s == 3'd2) return a & ~32'h3;
      if (s == 3'd1) return a & ~32'h1;
      return a;
   endfunction

   // ---------------- AHB slave with RAM, waits and errors ----------------
   logic [31:0] mem [logic [29:0]];
   bit          dp_valid = 0, dp_write = 0, dp_err = 0, err_stage = 0;
   logic [31:0] dp_addr = '0;
   logic [2:0]  dp_size = '0;
   int          wait_cnt = 0;
   int          wait_q[$];
   bit          rand_waits = 0;

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
   endfunction

   function automatic void wr_mem(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      logic [31:0] m, old;
      case (s)
         3'd0:    m = 32'hFF << {a[1:0], 3'b000};
         3'd1:    m = 32'hFFFF << {a[1], 4'b0000};
         default: m = 32'hFFFF_FFFF;
      endcase
      old = rd_mem(a);
      mem[a[31:2]] = (old & ~m) | (d & m);
   endfunction

   // Model + compare + slave: evaluate at negedge, drive slave just after posedge.
   initial begin
      bit has_a, has_d, rdy;
      txn_t t;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      forever begin
         @(negedge HCLK);
         has_a = (q.size() > 0) && !q[q.size()-1].in_data;
         has_d = (q.size() > 0) && q[0].in_data;
         if (seen_rst) begin
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("cmd_ready", 32'(cmd_ready), 32'(HREADY || !has_a));
            chk("htrans", 32'(HTRANS), has_a ? 32'h2 : 32'h0);
            if (has_a) begin
               chk("haddr", HADDR, q[q.size()-1].addr);
               chk("hsize", 32'(HSIZE), 32'(q[q.size()-1].size));
               chk("hwrite", 32'(HWRITE), 32'(q[q.size()-1].write));
            end
            if (has_d && q[0].write) chk("hwdata", HWDATA, q[0].wdata);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
               chk("rsp_rdata", rsp_rdata, exp_rd);
               chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
            chk("hburst", 32'(HBURST), 32'h0);
            chk("hprot", 32'(HPROT), 32'h3);
            chk("hmastlock", 32'(HMASTLOCK), 32'h0);
         end

         // model advance for this edge
         if (!HRESETn) begin
            q.delete();
            exp_rv = 0;
            seen_rst = 1;
         end else begin
            exp_rv = 0;
            if (HREADY && has_d) begin
               exp_rv  = 1;
               exp_rd  = q[0].write ? 32'h0 : HRDATA;
               exp_err = HRESP;
               void'(q.pop_front());
            end
            if (HREADY) foreach (q[i]) q[i].in_data = 1;
            rdy = HREADY || !has_a;
            if (cmd_valid && rdy) begin
               t.addr = ref_align(cmd_addr, cmd_size);
               t.size = cmd_size; t.write = cmd_write; t.wdata = cmd_wdata; t.in_data = 0;
               q.push_back(t);
            end
         end

         // slave advance for this edge
         if (!HRESETn) dp_valid = 0;
         else if (HREADY) begin
            if (dp_valid && dp_write && !dp_err) wr_mem(dp_addr, dp_size, HWDATA);
            if (HTRANS == 2'b10) begin
               dp_valid = 1; dp_addr = HADDR; dp_write = HWRITE; dp_size = HSIZE;
               dp_err = (HADDR[31:28] == 4'h4); err_stage = 0;
               if (wait_q.size() > 0) wait_cnt = wait_q.pop_front();
               else if (rand_waits) wait_cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
               else wait_cnt = 0;
            end else dp_valid = 0;
         end else if (dp_valid) begin
            if (dp_err) err_stage = 1;
            else if (wait_cnt > 0) wait_cnt--;
         end

         @(posedge HCLK); #1;
         if (!dp_valid) begin
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
         end else if (dp_err) begin
            HREADY = err_stage; HRESP = 1'b1; HRDATA = $urandom;
         end else if (wait_cnt > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
         end else begin
            HREADY = 1'b1; HRESP = 1'b0;
            HRDATA = dp_write ? $urandom : rd_mem(dp_addr);
         end
      end
   end

   // ---------------- stimulus and hand-computed expectations ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   // Called just after a posedge; returns just after the accepting edge.
   task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      bit ok;
      ok = 0;
      cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d; cmd_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge HCLK);
         if (cmd_ready) begin ok = 1; break; end
         @(posedge HCLK); #1;
      end
      if (!ok) chk("send_timeout", 32'h0, 32'h1);
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // reset state
      @(negedge HCLK);
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hsize", 32'(HSIZE), 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      idle(1);

      // write word
      send(1'b1, 32'h100, 3'd2, 32'hDEAD_BEEF);
      @(negedge HCLK);
      chk("wr_htrans", 32'(HTRANS), 32'h2);
      chk("wr_haddr", HADDR, 32'h100);
      chk("wr_hwrite", 32'(HWRITE), 32'h1);
      @(negedge HCLK);
      chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
      chk("wr_rsp_early", 32'(rsp_valid), 32'h0);
      @(negedge HCLK);
      chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("wr_rsp_err", 32'(rsp_err), 32'h0);
      idle(3);

      // read back, response exactly 3 cycles after accept
      send(1'b0, 32'h100, 3'd2, 32'h0);
      @(negedge HCLK); chk("rd_rsp_n1", 32'(rsp_valid), 32'h0);
      @(negedge HCLK); chk("rd_rsp_n2", 32'(rsp_valid), 32'h0);
      @(negedge HCLK);
      chk("rd_rsp_n3", 32'(rsp_valid), 32'h1);
      chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
      idle(3);

      // back-to-back reads
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 3'd2; cmd_wdata = '0;
      for (int i = 0; i < 4; i++) begin
         cmd_addr = 32'h100 + 32'(4 * i);
         @(negedge HCLK);
         chk("b2b_ready", 32'(cmd_ready), 32'h1);
         if (i > 0) chk("b2b_haddr", HADDR, 32'h100 + 32'(4 * (i - 1)));
         if (i == 3) begin
            chk("b2b_rsp0", 32'(rsp_valid), 32'h1);
            chk("b2b_rdata0", rsp_rdata, 32'hDEAD_BEEF);
         end
         @(posedge HCLK); #1;
      end
      cmd_valid = 1'b0;
      @(negedge HCLK);
      chk("b2b_haddr3", HADDR, 32'h10C);
      chk("b2b_rsp1", 32'(rsp_valid), 32'h1);
      @(negedge HCLK); chk("b2b_rsp2", 32'(rsp_valid), 32'h1);
      @(negedge HCLK); chk("b2b_rsp3", 32'(rsp_valid), 32'h1);
      @(negedge HCLK); chk("b2b_rsp_end", 32'(rsp_valid), 32'h0);
      idle(3);

      // wait states on the first of two writes
      wait_q.push_back(2); wait_q.push_back(0);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 3'd2;
      cmd_addr = 32'h110; cmd_wdata = 32'h1111_1111;
      @(negedge HCLK); chk("ws_ready0", 32'(cmd_ready), 32'h1);
      @(posedge HCLK); #1;
      cmd_addr = 32'h114; cmd_wdata = 32'h2222_2222;
      @(negedge HCLK); chk("ws_ready1", 32'(cmd_ready), 32'h1);
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK);
         chk("ws_haddr", HADDR, 32'h114);
         chk("ws_htrans", 32'(HTRANS), 32'h2);
         chk("ws_ready", 32'(cmd_ready), 32'h0);
         chk("ws_hwdata", HWDATA, 32'h1111_1111);
         chk("ws_rsp", 32'(rsp_valid), 32'h0);
      end
      @(negedge HCLK); chk("ws_rsp_c4", 32'(rsp_valid), 32'h0);
      @(negedge HCLK);
      chk("ws_rsp_a", 32'(rsp_valid), 32'h1);
      chk("ws_hwdata_b", HWDATA, 32'h2222_2222);
      @(negedge HCLK); chk("ws_rsp_b", 32'(rsp_valid), 32'h1);
      idle(3);

      // error response on the first of two pipelined reads
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 3'd2; cmd_wdata = '0;
      cmd_addr = 32'h4000_0000;
      @(posedge HCLK); #1;
      cmd_addr = 32'h110;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      @(negedge HCLK);
      chk("err_haddr_held", HADDR, 32'h110);
      chk("err_htrans_held", 32'(HTRANS), 32'h2);
      @(negedge HCLK);
      @(negedge HCLK);
      chk("err_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("err_rsp_err", 32'(rsp_err), 32'h1);
      @(negedge HCLK);
      chk("err_next_valid", 32'(rsp_valid), 32'h1);
      chk("err_next_err", 32'(rsp_err), 32'h0);
      chk("err_next_rdata", rsp_rdata, 32'h1111_1111);
      idle(3);

      // reset during a data-phase wait
      wait_q.push_back(5);
      send(1'b0, 32'h108, 3'd2, 32'h0);
      @(posedge HCLK); #1;
      HRESETn = 1'b0;
      @(negedge HCLK); chk("rstmid_busy_before", 32'(busy), 32'h1);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("rstmid_htrans", 32'(HTRANS), 32'h0);
      chk("rstmid_busy", 32'(busy), 32'h0);
      chk("rstmid_rsp", 32'(rsp_valid), 32'h0);
      @(negedge HCLK); chk("rstmid_rsp2", 32'(rsp_valid), 32'h0);
      wait_q.delete();
      idle(2);

      // randomized traffic against the model
      rand_waits = 1;
      repeat (3000) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_write = 1'($urandom);
         cmd_size  = 3'($urandom_range(0, 2));
         cmd_addr  = ($urandom_range(0, 15) == 0) ? (32'h4000_0000 | ($urandom & 32'hFF))
                                                  : (32'h100 | ($urandom & 32'h3F));
         cmd_wdata = $urandom;
         HRESETn   = ($urandom_range(0, 499) != 0);
         @(posedge HCLK); #1;
      end
      cmd_valid = 1'b0;
      HRESETn = 1'b1;
      idle(12);
      @(negedge HCLK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
